// File: rtl/legv8_mc_ctrl_if.sv
// Control bus between the LEGv8 multicycle main controller and its datapath.
// The master side is the controller; the slave side is the datapath/memory.
interface legv8_mc_ctrl_if;
   logic [10:0] opcode;
   logic        mem_ready;
   logic        pc_write;
   logic        pc_write_cond;
   logic [1:0]  pc_src;
   logic        ior_d;
   logic        mem_rd;
   logic        mem_wr;
   logic        ir_write;
   logic        reg2_loc;
   logic        reg_write;
   logic        mem_to_reg;
   logic        alu_src_a;
   logic [1:0]  alu_src_b;
   logic [1:0]  alu_op;
   logic        fault;
   logic [1:0]  fault_cause;
   logic [3:0]  state;

   modport master (
      input  opcode, mem_ready,
      output pc_write, pc_write_cond, pc_src, ior_d, mem_rd, mem_wr, ir_write,
             reg2_loc, reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op,
             fault, fault_cause, state
   );

   modport slave (
      output opcode, mem_ready,
      input  pc_write, pc_write_cond, pc_src, ior_d, mem_rd, mem_wr, ir_write,
             reg2_loc, reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op,
             fault, fault_cause, state
   );
endinterface

// File: rtl/legv8_mc_ctrl.sv
// LEGv8 multicycle main control FSM: fetch/decode/execute/memory/writeback
// sequencing, datapath strobes, ALU_OP for the ALU control decoder, memory watchdog.
module legv8_mc_ctrl #(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned CNT_W   = 8
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   legv8_mc_ctrl_if.master io_bus
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEM_ADDR = 4'd2,
      S_MEM_READ = 4'd3,
      S_MEM_WB   = 4'd4,
      S_MEM_WRITE= 4'd5,
      S_R_EXEC   = 4'd6,
      S_R_WB     = 4'd7,
      S_CBZ_EXEC = 4'd8,
      S_B_EXEC   = 4'd9,
      S_HALT     = 4'd15
   } state_t;

   localparam logic [CNT_W:0] L_TIMEOUT = (CNT_W+1)'(TIMEOUT);
   localparam logic           L_WDOG_EN = (TIMEOUT != 0) ? 1'b1 : 1'b0;
   localparam logic [1:0]     L_CAUSE_ILLEGAL = 2'b01;
   localparam logic [1:0]     L_CAUSE_TIMEOUT = 2'b10;

   function automatic logic f_is_ldur(input logic [10:0] op);
      return op == 11'b11111000010;
   endfunction

   function automatic logic f_is_stur(input logic [10:0] op);
      return op == 11'b11111000000;
   endfunction

   function automatic logic f_is_rtype(input logic [10:0] op);
      return (op == 11'b10001011000) || (op == 11'b11001011000) ||
             (op == 11'b10001010000) || (op == 11'b10101010000);
   endfunction

   function automatic logic f_is_cbz(input logic [10:0] op);
      return op[10:3] == 8'b10110100;
   endfunction

   function automatic logic f_is_b(input logic [10:0] op);
      return op[10:5] == 6'b000101;
   endfunction

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_cnt;
   logic [1:0]       r_cause;
   logic [1:0]       w_cause_next;
   logic [CNT_W:0]   w_cnt_inc;
   logic             w_wait;
   logic             w_timeout;

   logic       w_pc_write;
   logic       w_pc_write_cond;
   logic [1:0] w_pc_src;
   logic       w_ior_d;
   logic       w_mem_rd;
   logic       w_mem_wr;
   logic       w_ir_write;
   logic       w_reg2_loc;
   logic       w_reg_write;
   logic       w_mem_to_reg;
   logic       w_alu_src_a;
   logic [1:0] w_alu_src_b;
   logic [1:0] w_alu_op;
   logic       w_fault;

   assign w_wait    = (r_state == S_FETCH) || (r_state == S_MEM_READ) ||
                      (r_state == S_MEM_WRITE);
   assign w_cnt_inc = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
   // Fires on the wait cycle whose increment would reach TIMEOUT; a ready in that cycle wins.
   assign w_timeout = L_WDOG_EN && w_wait && !io_bus.mem_ready && (w_cnt_inc == L_TIMEOUT);

   // State register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_FETCH;
      end else begin
         r_state <= w_next;
      end
   end

   // Sticky fault cause, captured on entry to HALT
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cause <= 2'b00;
      end else begin
         r_cause <= w_cause_next;
      end
   end

   // Memory-wait watchdog counter
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= {CNT_W{1'b0}};
      end else if (w_next != r_state) begin
         r_cnt <= {CNT_W{1'b0}};
      end else if (w_wait && !io_bus.mem_ready) begin
         r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         r_cnt <= r_cnt;
      end
   end

   // Next-state and strobe decode
   always_comb begin
      w_next          = r_state;
      w_cause_next    = r_cause;
      w_pc_write      = 1'b0;
      w_pc_write_cond = 1'b0;
      w_pc_src        = 2'b00;
      w_ior_d         = 1'b0;
      w_mem_rd        = 1'b0;
      w_mem_wr        = 1'b0;
      w_ir_write      = 1'b0;
      w_reg2_loc      = 1'b0;
      w_reg_write     = 1'b0;
      w_mem_to_reg    = 1'b0;
      w_alu_src_a     = 1'b0;
      w_alu_src_b     = 2'b00;
      w_alu_op        = 2'b00;
      w_fault         = 1'b0;

      case (r_state)
         S_FETCH: begin
            w_mem_rd    = 1'b1;
            w_alu_src_b = 2'b01;
            if (io_bus.mem_ready) begin
               w_ir_write = 1'b1;
               w_pc_write = 1'b1;
               w_next     = S_DECODE;
            end else if (w_timeout) begin
               w_next       = S_HALT;
               w_cause_next = L_CAUSE_TIMEOUT;
            end else begin
               w_next = S_FETCH;
            end
         end
         S_DECODE: begin
            // PC + branch offset is parked in ALUOut for CBZ/B
            w_alu_src_b = 2'b11;
            if (f_is_ldur(io_bus.opcode) || f_is_stur(io_bus.opcode)) begin
               w_next = S_MEM_ADDR;
            end else if (f_is_rtype(io_bus.opcode)) begin
               w_next = S_R_EXEC;
            end else if (f_is_cbz(io_bus.opcode)) begin
               w_next = S_CBZ_EXEC;
            end else if (f_is_b(io_bus.opcode)) begin
               w_next = S_B_EXEC;
            end else begin
               w_next       = S_HALT;
               w_cause_next = L_CAUSE_ILLEGAL;
            end
         end
         S_MEM_ADDR: begin
            w_alu_src_a = 1'b1;
            w_alu_src_b = 2'b10;
            if (f_is_ldur(io_bus.opcode)) begin
               w_next = S_MEM_READ;
            end else begin
               w_next = S_MEM_WRITE;
            end
         end
         S_MEM_READ: begin
            w_ior_d  = 1'b1;
            w_mem_rd = 1'b1;
            if (io_bus.mem_ready) begin
               w_next = S_MEM_WB;
            end else if (w_timeout) begin
               w_next       = S_HALT;
               w_cause_next = L_CAUSE_TIMEOUT;
            end else begin
               w_next = S_MEM_READ;
            end
         end
         S_MEM_WB: begin
            w_reg_write  = 1'b1;
            w_mem_to_reg = 1'b1;
            w_next       = S_FETCH;
         end
         S_MEM_WRITE: begin
            w_ior_d  = 1'b1;
            w_mem_wr = 1'b1;
            if (io_bus.mem_ready) begin
               w_next = S_FETCH;
            end else if (w_timeout) begin
               w_next       = S_HALT;
               w_cause_next = L_CAUSE_TIMEOUT;
            end else begin
               w_next = S_MEM_WRITE;
            end
         end
         S_R_EXEC: begin
            w_alu_src_a = 1'b1;
            w_alu_op    = 2'b10;
            w_next      = S_R_WB;
         end
         S_R_WB: begin
            w_reg_write = 1'b1;
            w_next      = S_FETCH;
         end
         S_CBZ_EXEC: begin
            w_alu_src_a     = 1'b1;
            w_alu_op        = 2'b01;
            w_pc_write_cond = 1'b1;
            w_pc_src        = 2'b01;
            w_next          = S_FETCH;
         end
         S_B_EXEC: begin
            w_pc_write = 1'b1;
            w_pc_src   = 2'b01;
            w_next     = S_FETCH;
         end
         S_HALT: begin
            w_fault = 1'b1;
            w_next  = S_HALT;
         end
         default: begin
            // Unreachable encodings park safely in HALT
            w_next = S_HALT;
         end
      endcase

      if (r_state != S_HALT) begin
         w_reg2_loc = f_is_stur(io_bus.opcode) || f_is_cbz(io_bus.opcode);
      end else begin
         w_reg2_loc = 1'b0;
      end
   end

   // Reset masks every output immediately so no partial strobe survives an abort
   assign io_bus.pc_write      = i_rst_n & w_pc_write;
   assign io_bus.pc_write_cond = i_rst_n & w_pc_write_cond;
   assign io_bus.pc_src        = {2{i_rst_n}} & w_pc_src;
   assign io_bus.ior_d         = i_rst_n & w_ior_d;
   assign io_bus.mem_rd        = i_rst_n & w_mem_rd;
   assign io_bus.mem_wr        = i_rst_n & w_mem_wr;
   assign io_bus.ir_write      = i_rst_n & w_ir_write;
   assign io_bus.reg2_loc      = i_rst_n & w_reg2_loc;
   assign io_bus.reg_write     = i_rst_n & w_reg_write;
   assign io_bus.mem_to_reg    = i_rst_n & w_mem_to_reg;
   assign io_bus.alu_src_a     = i_rst_n & w_alu_src_a;
   assign io_bus.alu_src_b     = {2{i_rst_n}} & w_alu_src_b;
   assign io_bus.alu_op        = {2{i_rst_n}} & w_alu_op;
   assign io_bus.fault         = i_rst_n & w_fault;
   assign io_bus.fault_cause   = {2{i_rst_n}} & r_cause;
   assign io_bus.state         = {4{i_rst_n}} & r_state;

endmodule

// File: tb/tb_legv8_mc_ctrl.sv
// Scoreboard bench for legv8_mc_ctrl: the driver queues hand-written expected
// output words per cycle; a negedge monitor pops and compares them.
module tb_legv8_mc_ctrl;

   typedef struct packed {
      logic [3:0] st;
      logic       pcw;
      logic       pcwc;
      logic [1:0] pcs;
      logic       iord;
      logic       mrd;
      logic       mwr;
      logic       irw;
      logic       r2l;
      logic       rw;
      logic       m2r;
      logic       asa;
      logic [1:0] asb;
      logic [1:0] aop;
      logic       flt;
      logic [1:0] fc;
   } vec_t;

   typedef struct {
      vec_t  e;
      string tag;
   } exp_t;

   //                         st     pcw   pcwc  pcs    iord  mrd   mwr   irw   r2l   rw    m2r   asa   asb    aop    flt   fc
   localparam vec_t E_ZERO  = '{4'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00};
   localparam vec_t E_FETCH = '{4'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 2'b00};
   localparam vec_t E_FETCHR= '{4'd0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 2'b00};
   localparam vec_t E_DEC   = '{4'd1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0, 2'b00};
   localparam vec_t E_MADDR = '{4'd2, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 1'b0, 2'b00};
   localparam vec_t E_MREAD = '{4'd3, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00};
   localparam vec_t E_MWB   = '{4'd4, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00};
   localparam vec_t E_MWRITE= '{4'd5, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00};
   localparam vec_t E_REXEC = '{4'd6, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b10, 1'b0, 2'b00};
   localparam vec_t E_RWB   = '{4'd7, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00};
   localparam vec_t E_CBZ   = '{4'd8, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 1'b0, 2'b00};
   localparam vec_t E_B     = '{4'd9, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00};
   localparam vec_t E_HALT1 = '{4'd15,1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 2'b01};
   localparam vec_t E_HALT2 = '{4'd15,1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 2'b10};

   localparam logic [10:0] OP_ADD  = 11'b10001011000;
   localparam logic [10:0] OP_LDUR = 11'b11111000010;
   localparam logic [10:0] OP_STUR = 11'b11111000000;
   localparam logic [10:0] OP_CBZ  = 11'b10110100101;
   localparam logic [10:0] OP_B    = 11'b00010100000;
   localparam logic [10:0] OP_ILL  = 11'b11111111111;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_pass;
   exp_t sb_q[$];

   legv8_mc_ctrl_if bus ();

   legv8_mc_ctrl #(.TIMEOUT(4), .CNT_W(3)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .io_bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t r2(input vec_t e);
      vec_t v;
      v     = e;
      v.r2l = 1'b1;
      return v;
   endfunction

   // Drive one cycle of inputs and queue the outputs expected during it
   task automatic cyc(input logic rdy, input vec_t e, input string tag);
      exp_t x;
      bus.mem_ready = rdy;
      x.e   = e;
      x.tag = tag;
      sb_q.push_back(x);
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare the DUT output word against the queued expectation
   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         exp_t x;
         vec_t got;
         x   = sb_q.pop_front();
         got = '{bus.state, bus.pc_write, bus.pc_write_cond, bus.pc_src, bus.ior_d,
                 bus.mem_rd, bus.mem_wr, bus.ir_write, bus.reg2_loc, bus.reg_write,
                 bus.mem_to_reg, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                 bus.fault, bus.fault_cause};
         n_checks = n_checks + 1;
         if (got === x.e) begin
            n_pass = n_pass + 1;
         end else begin
            $display("FAIL %s: got state=%0d word=%06h, expected state=%0d word=%06h",
                     x.tag, got.st, got, x.e.st, x.e);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      n_checks      = 0;
      n_pass        = 0;
      rst_n         = 1'b0;
      bus.opcode    = OP_ADD;
      bus.mem_ready = 1'b0;
      @(posedge clk);
      #1;

      // reset: everything quiet
      cyc(1'b1, E_ZERO, "reset0");
      cyc(1'b0, E_ZERO, "reset1");
      rst_n = 1'b1;

      // ADD: 4 cycles
      cyc(1'b1, E_FETCHR, "add_fetch");
      cyc(1'b1, E_DEC,    "add_decode");
      cyc(1'b0, E_REXEC,  "add_rexec");
      cyc(1'b1, E_RWB,    "add_rwb");

      // LDUR with 2 wait cycles in MEM_READ
      bus.opcode = OP_LDUR;
      cyc(1'b1, E_FETCHR, "ldur_fetch");
      cyc(1'b0, E_DEC,    "ldur_decode");
      cyc(1'b1, E_MADDR,  "ldur_maddr");
      cyc(1'b0, E_MREAD,  "ldur_wait1");
      cyc(1'b0, E_MREAD,  "ldur_wait2");
      cyc(1'b1, E_MREAD,  "ldur_ready");
      cyc(1'b0, E_MWB,    "ldur_wb");

      // STUR: 4 cycles, REG2_LOC=1
      bus.opcode = OP_STUR;
      cyc(1'b1, r2(E_FETCHR), "stur_fetch");
      cyc(1'b0, r2(E_DEC),    "stur_decode");
      cyc(1'b0, r2(E_MADDR),  "stur_maddr");
      cyc(1'b1, r2(E_MWRITE), "stur_write");

      // CBZ and B: 3 cycles each
      bus.opcode = OP_CBZ;
      cyc(1'b1, r2(E_FETCHR), "cbz_fetch");
      cyc(1'b0, r2(E_DEC),    "cbz_decode");
      cyc(1'b1, r2(E_CBZ),    "cbz_exec");
      bus.opcode = OP_B;
      cyc(1'b1, E_FETCHR, "b_fetch");
      cyc(1'b1, E_DEC,    "b_decode");
      cyc(1'b0, E_B,      "b_exec");

      // ready on the 4th FETCH wait cycle beats the watchdog
      bus.opcode = OP_ADD;
      for (int i = 0; i < 3; i++) cyc(1'b0, E_FETCH, "wd_edge_wait");
      cyc(1'b1, E_FETCHR, "wd_edge_ready");
      cyc(1'b0, E_DEC,    "wd_edge_decode");
      cyc(1'b0, E_REXEC,  "wd_edge_rexec");
      cyc(1'b0, E_RWB,    "wd_edge_rwb");

      // STUR held 3 cycles in MEM_WRITE, then reset aborts it
      bus.opcode = OP_STUR;
      cyc(1'b1, r2(E_FETCHR), "abort_fetch");
      cyc(1'b0, r2(E_DEC),    "abort_decode");
      cyc(1'b0, r2(E_MADDR),  "abort_maddr");
      for (int i = 0; i < 3; i++) cyc(1'b0, r2(E_MWRITE), "abort_write_wait");
      rst_n = 1'b0;
      cyc(1'b1, E_ZERO, "abort_reset0");
      cyc(1'b1, E_ZERO, "abort_reset1");
      bus.opcode = OP_ADD;
      rst_n = 1'b1;
      // counter must restart: 3 more waits do not fault
      for (int i = 0; i < 3; i++) cyc(1'b0, E_FETCH, "restart_wait");
      cyc(1'b1, E_FETCHR, "restart_ready");
      cyc(1'b0, E_DEC,    "restart_decode");
      cyc(1'b0, E_REXEC,  "restart_rexec");
      cyc(1'b0, E_RWB,    "restart_rwb");

      // FETCH timeout after 4 wait cycles
      for (int i = 0; i < 4; i++) cyc(1'b0, E_FETCH, "to_wait");
      cyc(1'b1, E_HALT2, "to_halt0");
      cyc(1'b0, E_HALT2, "to_halt1");
      cyc(1'b1, E_HALT2, "to_halt2");
      rst_n = 1'b0;
      cyc(1'b0, E_ZERO, "to_reset");
      rst_n = 1'b1;

      // illegal opcode -> sticky HALT, MEM_READY ignored
      bus.opcode = OP_ILL;
      cyc(1'b1, E_FETCHR, "ill_fetch");
      cyc(1'b0, E_DEC,    "ill_decode");
      for (int i = 0; i < 20; i++) cyc(logic'(i % 2), E_HALT1, "ill_halt");

      @(negedge clk);
      n_checks = n_checks + 1;
      if (sb_q.size() == 0) begin
         n_pass = n_pass + 1;
      end else begin
         $display("FAIL sb_drain: %0d entries left, expected 0", sb_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/legv8_mc_ctrl.md
Name: legv8_mc_ctrl

Overview:
Multicycle main control FSM for the LEGv8 core. It sits directly upstream of the ALU control decoder. It produces the 2-bit ALU_OP that the decoder consumes, using the decoder's encoding: 00 ADD, 01 PASS B, 10 R-type/funct. It also produces every datapath, register-file and memory strobe, and sequences each instruction through fetch, decode, execute, memory and writeback. Memory accesses use a ready handshake with a timeout watchdog.

Parameters:
TIMEOUT, 255, consecutive MEM_READY-low cycles in a memory wait state before FAULT; 0 disables the watchdog.
CNT_W, 8, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
CLK  input  1  clock, rising edge
RST_N  input  1  asynchronous active-low reset
OPCODE  input  11  IR[31:21] from the instruction register
MEM_READY  input  1  memory completed the current read/write this cycle
PC_WRITE  output  1  unconditional PC load
PC_WRITE_COND  output  1  PC load if datapath ZERO=1
PC_SRC  output  2  00 ALU result, 01 ALUOut register
IOR_D  output  1  memory address: 0 PC, 1 ALUOut
MEM_RD  output  1  memory read request
MEM_WR  output  1  memory write request
IR_WRITE  output  1  load instruction register
REG2_LOC  output  1  register read port 2: 0 Rm (IR[20:16]), 1 Rt (IR[4:0])
REG_WRITE  output  1  register-file write enable
MEM_TO_REG  output  1  writeback source: 0 ALUOut, 1 MDR
ALU_SRC_A  output  1  0 PC, 1 register A
ALU_SRC_B  output  2  00 register B, 01 constant 4, 10 sext D-imm, 11 sext branch offset <<2
ALU_OP  output  2  to ALU control decoder
FAULT  output  1  sticky fault flag
FAULT_CAUSE  output  2  01 illegal opcode, 10 memory timeout, 00 none
STATE  output  4  current state encoding, for debug

Behaviour:
- States: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, R_EXEC=6, R_WB=7, CBZ_EXEC=8, B_EXEC=9, HALT=15. The state register resets asynchronously to FETCH.
- Reset: while RST_N=0, all outputs are 0 and the watchdog counter is 0. Decoding resumes on the first rising edge after RST_N goes high.
- Unlisted outputs are 0 in every state.
- FETCH:
  - Outputs: MEM_RD=1, IOR_D=0, ALU_SRC_A=0, ALU_SRC_B=01, ALU_OP=00, PC_SRC=00.
  - IR_WRITE and PC_WRITE are Mealy outputs, asserted only in a cycle where MEM_READY=1. That cycle transitions to DECODE; otherwise the FSM stays in FETCH.
- DECODE:
  - Outputs: ALU_SRC_A=0, ALU_SRC_B=11, ALU_OP=00 (branch target into ALUOut).
  - Next state by OPCODE: LDUR 11111000010 or STUR 11111000000 -> MEM_ADDR. ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000 -> R_EXEC. CBZ OPCODE[10:3]=10110100 -> CBZ_EXEC. B OPCODE[10:5]=000101 -> B_EXEC. Anything else -> HALT with cause 01.
- MEM_ADDR:
  - Outputs: ALU_SRC_A=1, ALU_SRC_B=10, ALU_OP=00.
  - Next state: LDUR -> MEM_READ, STUR -> MEM_WRITE.
- MEM_READ: IOR_D=1, MEM_RD=1. Goes to MEM_WB on MEM_READY=1.
- MEM_WB: REG_WRITE=1, MEM_TO_REG=1. Goes to FETCH.
- MEM_WRITE: IOR_D=1, MEM_WR=1. Goes to FETCH on MEM_READY=1.
- R_EXEC: ALU_SRC_A=1, ALU_SRC_B=00, ALU_OP=10. Goes to R_WB.
- R_WB: REG_WRITE=1, MEM_TO_REG=0. Goes to FETCH.
- CBZ_EXEC: ALU_SRC_A=1, ALU_SRC_B=00, ALU_OP=01 (pass Rt), PC_WRITE_COND=1, PC_SRC=01. Goes to FETCH.
- B_EXEC: PC_WRITE=1, PC_SRC=01. Goes to FETCH.
- REG2_LOC: combinational from OPCODE in all non-HALT states. It is 1 for STUR and CBZ, 0 otherwise.
- Cycle counts with zero memory wait: R-type 4, LDUR 5, STUR 4, CBZ 3, B 3.
- Watchdog:
  - The counter clears on every state change. It increments each cycle the FSM sits in FETCH, MEM_READ or MEM_WRITE with MEM_READY=0.
  - When the counter reaches TIMEOUT (TIMEOUT≠0) with MEM_READY still 0, the next state is HALT with cause 10.
  - MEM_READY=1 in the same cycle that the count reaches TIMEOUT wins: normal transition, no fault.
- HALT:
  - All strobes are 0. FAULT=1. FAULT_CAUSE holds its value.
  - Only RST_N exits HALT. MEM_READY is ignored.
- MEM_READY outside the wait states is ignored.
- Reset asserted mid-instruction aborts it immediately. No partial strobe is asserted after RST_N falls.

Test Plan:
- Reset, then ADD (OPCODE 10001011000) with MEM_READY=1 in FETCH -> STATE 0,1,6,7,0. ALU_OP 00,00,10,xx. REG_WRITE=1 only in R_WB with MEM_TO_REG=0. Total 4 cycles.
- LDUR with MEM_READY held low 2 cycles in MEM_READ -> STATE stays 3 for 3 cycles. MEM_RD=1 and IOR_D=1 throughout. Then MEM_WB with REG_WRITE=1, MEM_TO_REG=1.
- CBZ (OPCODE 10110100101) and B (00010100000) -> CBZ_EXEC shows ALU_OP=01, PC_WRITE_COND=1, PC_SRC=01, REG2_LOC=1. B_EXEC shows PC_WRITE=1, PC_SRC=01. Each takes 3 cycles.
- Illegal OPCODE 11111111111 in DECODE -> STATE=15, FAULT=1, FAULT_CAUSE=01. Strobes stay 0 for 20 cycles despite MEM_READY toggling.
- TIMEOUT=4, MEM_READY low in FETCH -> HALT entered after 4 wait cycles, FAULT_CAUSE=10. Repeat with MEM_READY=1 on the 4th wait cycle -> no fault; DECODE reached.
- RST_N pulsed low during MEM_WRITE -> outputs 0 immediately. After release STATE=FETCH, FAULT=0, counter restarts.
